// File: rtl/l1_weight_read_ctrl.sv
`timescale 1ns/1ps
// l1_weight_read_ctrl
// Walks the layer-1 weight store one LANES-wide slice per read and tags the
// returned data so the MAC array can clear, accumulate and commit each neuron.
//
// Ports:
//   i_clk           system clock, rising edge
//   i_rst           synchronous active-high reset
//   i_start         start one full pass (sampled in IDLE only)
//   i_mac_ready     MAC can take a slice; low stalls issue for that edge
//   o_re_en         SRAM read enable
//   o_re_addr_byte  slice start address 1 + chunk*LANES
//   o_re_addr_img   neuron address 1..N_OUT
//   o_data_valid    SRAM outputs hold a real slice this cycle
//   o_first_chunk   slice 0 of a neuron (clear accumulator)
//   o_last_chunk    final slice of a neuron (commit)
//   o_neuron_idx    neuron number of the returned slice
//   o_busy          pass in progress, through the done cycle
//   o_done          one-cycle end-of-pass pulse
module l1_weight_read_ctrl #(
    parameter int unsigned N_IN  = 784,
    parameter int unsigned N_OUT = 200,
    parameter int unsigned LANES = 98
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic       i_mac_ready,
    output logic       o_re_en,
    output logic [9:0] o_re_addr_byte,
    output logic [7:0] o_re_addr_img,
    output logic       o_data_valid,
    output logic       o_first_chunk,
    output logic       o_last_chunk,
    output logic [7:0] o_neuron_idx,
    output logic       o_busy,
    output logic       o_done
);

    localparam int unsigned CHUNK_W  = 3;
    localparam int unsigned NEURON_W = 8;
    localparam int unsigned BYTE_W   = 10;
    localparam int unsigned N_CHUNK  = N_IN / LANES;

    localparam logic [CHUNK_W-1:0]  LAST_CHUNK   = CHUNK_W'(N_CHUNK - 1);
    localparam logic [NEURON_W-1:0] FIRST_NEURON = NEURON_W'(1);
    localparam logic [NEURON_W-1:0] END_NEURON   = NEURON_W'(N_OUT + 1);
    localparam logic [BYTE_W-1:0]   BYTE_FIRST   = BYTE_W'(1);
    localparam logic [BYTE_W-1:0]   BYTE_STEP    = BYTE_W'(LANES);
    localparam logic [BYTE_W-1:0]   BYTE_LAST    = BYTE_W'(1 + (N_CHUNK - 1) * LANES);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]          r_state;
    logic [CHUNK_W-1:0]  r_chunk;
    logic [NEURON_W-1:0] r_neuron;
    logic [BYTE_W-1:0]   r_byte;

    logic [1:0]          w_next_state;
    logic                w_issue;
    logic [CHUNK_W-1:0]  w_cur_chunk;
    logic [NEURON_W-1:0] w_cur_neuron;
    logic [BYTE_W-1:0]   w_cur_byte;
    logic [CHUNK_W-1:0]  w_nxt_chunk;
    logic [NEURON_W-1:0] w_nxt_neuron;
    logic [BYTE_W-1:0]   w_nxt_byte;

    // Next state, issue decision and incremental address advance.
    // The neuron counter running one past N_OUT marks "every slice issued";
    // READ then leaves for DRAIN so that DRAIN covers the final tag cycle.
    always_comb begin
        w_next_state = r_state;
        w_issue      = 1'b0;
        w_cur_chunk  = r_chunk;
        w_cur_neuron = r_neuron;
        w_cur_byte   = r_byte;

        case (r_state)
            S_IDLE: begin
                w_cur_chunk  = '0;
                w_cur_neuron = FIRST_NEURON;
                w_cur_byte   = BYTE_FIRST;
                if (i_start) begin
                    w_next_state = S_READ;
                    w_issue      = i_mac_ready;
                end
            end
            S_READ: begin
                if (r_neuron == END_NEURON) begin
                    w_next_state = S_DRAIN;
                end else begin
                    w_issue = i_mac_ready;
                end
            end
            S_DRAIN: w_next_state = S_DONE;
            S_DONE:  w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase

        w_nxt_chunk  = w_cur_chunk;
        w_nxt_neuron = w_cur_neuron;
        w_nxt_byte   = w_cur_byte;
        if (w_issue) begin
            if (w_cur_chunk == LAST_CHUNK) begin
                w_nxt_chunk  = '0;
                w_nxt_byte   = BYTE_FIRST;
                w_nxt_neuron = w_cur_neuron + NEURON_W'(1);
            end else begin
                w_nxt_chunk  = w_cur_chunk + CHUNK_W'(1);
                w_nxt_byte   = w_cur_byte + BYTE_STEP;
            end
        end
    end

    // State, counters and registered SRAM/tag outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= S_IDLE;
            r_chunk        <= '0;
            r_neuron       <= FIRST_NEURON;
            r_byte         <= BYTE_FIRST;
            o_re_en        <= 1'b0;
            o_re_addr_byte <= '0;
            o_re_addr_img  <= '0;
            o_data_valid   <= 1'b0;
            o_first_chunk  <= 1'b0;
            o_last_chunk   <= 1'b0;
            o_neuron_idx   <= '0;
            o_busy         <= 1'b0;
            o_done         <= 1'b0;
        end else begin
            r_state  <= w_next_state;
            r_chunk  <= w_nxt_chunk;
            r_neuron <= w_nxt_neuron;
            r_byte   <= w_nxt_byte;

            o_re_en <= w_issue;
            if (w_issue) begin
                o_re_addr_byte <= w_cur_byte;
                o_re_addr_img  <= w_cur_neuron;
            end

            // Tags trail the issue by one cycle, when SRAM data is stable.
            o_data_valid  <= o_re_en;
            o_first_chunk <= o_re_en && (o_re_addr_byte == BYTE_FIRST);
            o_last_chunk  <= o_re_en && (o_re_addr_byte == BYTE_LAST);
            o_neuron_idx  <= o_re_en ? o_re_addr_img : '0;

            o_busy <= (w_next_state != S_IDLE);
            o_done <= (w_next_state == S_DONE);
        end
    end

endmodule
